// File: rtl/psr_window_unit.sv
// Processor Status Register with register-window pointer management and WIM checking.
// Optional macro PSR_ICC_BYPASS_EN forwards icc_in to N/Z/V/C in the same cycle.
module psr_window_unit #(
  parameter int unsigned NWINDOWS = 4,
  parameter int unsigned CWPW     = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                icc_we,
  input  logic [3:0]          icc_in,
  input  logic                wrpsr_we,
  input  logic [11:0]         wrpsr_data,
  input  logic                save_req,
  input  logic                restore_req,
  input  logic                trap_entry,
  input  logic                rett_req,
  input  logic [NWINDOWS-1:0] WIM,
  output logic [11:0]         PSR,
  output logic                N,
  output logic                Z,
  output logic                V,
  output logic                C,
  output logic [CWPW-1:0]     CWP,
  output logic                S,
  output logic                ET,
  output logic                win_ovf,
  output logic                win_unf,
  output logic                error_mode
);

  localparam int unsigned ICC_W = 4;
  localparam int unsigned LOW_W = 5;

  logic [ICC_W-1:0] icc_q;
  logic             s_q;
  logic             ps_q;
  logic             et_q;
  logic [CWPW-1:0]  cwp_q;
  logic [CWPW-1:0]  cwp_dec;
  logic [CWPW-1:0]  cwp_inc;
  logic             unused_rsvd;

  // Power-of-two window count lets the pointer wrap naturally.
  assign cwp_dec = cwp_q - CWPW'(1);
  assign cwp_inc = cwp_q + CWPW'(1);

  // Reserved bits of a WRPSR write are discarded.
  assign unused_rsvd = ^wrpsr_data[LOW_W-1:CWPW];

  // Single-winner priority: trap > rett > wrpsr > save/restore > icc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icc_q      <= '0;
      s_q        <= 1'b1;
      ps_q       <= 1'b0;
      et_q       <= 1'b0;
      cwp_q      <= '0;
      win_ovf    <= 1'b0;
      win_unf    <= 1'b0;
      error_mode <= 1'b0;
    end else begin
      win_ovf <= 1'b0;
      win_unf <= 1'b0;
      if (trap_entry) begin
        if (et_q) begin
          ps_q  <= s_q;
          s_q   <= 1'b1;
          et_q  <= 1'b0;
          cwp_q <= cwp_dec;
        end else begin
          error_mode <= 1'b1;
        end
      end else if (rett_req) begin
        if (WIM[cwp_inc]) begin
          win_unf <= 1'b1;
        end else begin
          cwp_q <= cwp_inc;
          s_q   <= ps_q;
          et_q  <= 1'b1;
        end
      end else if (wrpsr_we) begin
        icc_q <= wrpsr_data[11:8];
        s_q   <= wrpsr_data[7];
        ps_q  <= wrpsr_data[6];
        et_q  <= wrpsr_data[5];
        cwp_q <= wrpsr_data[CWPW-1:0];
      end else if (save_req || restore_req) begin
        // Simultaneous SAVE and RESTORE cancel out and still block icc.
        if (save_req && !restore_req) begin
          if (WIM[cwp_dec]) win_ovf <= 1'b1;
          else              cwp_q   <= cwp_dec;
        end else if (restore_req && !save_req) begin
          if (WIM[cwp_inc]) win_unf <= 1'b1;
          else              cwp_q   <= cwp_inc;
        end
      end else if (icc_we) begin
        icc_q <= icc_in;
      end
    end
  end

  assign PSR = {icc_q, s_q, ps_q, et_q, LOW_W'(cwp_q)};
  assign CWP = cwp_q;
  assign S   = s_q;
  assign ET  = et_q;

`ifdef PSR_ICC_BYPASS_EN
  logic icc_bypass_c;

  // Forward ALU flags when the icc update is the winning request this cycle.
  assign icc_bypass_c = icc_we && !trap_entry && !rett_req && !wrpsr_we
                        && !save_req && !restore_req;
  assign {N, Z, V, C} = icc_bypass_c ? icc_in : icc_q;
`else
  assign {N, Z, V, C} = icc_q;
`endif

endmodule

// File: tb/tb_psr_window_unit.sv
// Self-checking bench for psr_window_unit against a field-level PSR model.
module tb_psr_window_unit;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        icc_we;
  logic [3:0]  icc_in;
  logic        wrpsr_we;
  logic [11:0] wrpsr_data;
  logic        save_req;
  logic        restore_req;
  logic        trap_entry;
  logic        rett_req;
  logic [3:0]  WIM;
  logic [11:0] PSR;
  logic        N, Z, V, C;
  logic [1:0]  CWP;
  logic        S, ET;
  logic        win_ovf, win_unf, error_mode;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_icc, m_s, m_ps, m_et, m_cwp, m_ovf, m_unf, m_err;

  psr_window_unit #(.NWINDOWS(4), .CWPW(2)) dut (
    .clk(clk), .reset_n(reset_n), .icc_we(icc_we), .icc_in(icc_in),
    .wrpsr_we(wrpsr_we), .wrpsr_data(wrpsr_data), .save_req(save_req),
    .restore_req(restore_req), .trap_entry(trap_entry), .rett_req(rett_req),
    .WIM(WIM), .PSR(PSR), .N(N), .Z(Z), .V(V), .C(C), .CWP(CWP), .S(S),
    .ET(ET), .win_ovf(win_ovf), .win_unf(win_unf), .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_psr();
    return 12'(m_icc * 256 + m_s * 128 + m_ps * 64 + m_et * 32 + m_cwp);
  endfunction

  function automatic logic [3:0] exp_flags_now();
`ifdef PSR_ICC_BYPASS_EN
    if (icc_we && !trap_entry && !rett_req && !wrpsr_we && !save_req && !restore_req)
      return icc_in;
`endif
    return 4'(m_icc);
  endfunction

  task automatic model_reset();
    m_icc = 0; m_s = 1; m_ps = 0; m_et = 0; m_cwp = 0;
    m_ovf = 0; m_unf = 0; m_err = 0;
  endtask

  // Apply the architectural rules for the inputs currently driven.
  task automatic model_step();
    int nxt;
    m_ovf = 0;
    m_unf = 0;
    if (trap_entry) begin
      if (m_et == 1) begin
        m_ps = m_s; m_s = 1; m_et = 0; m_cwp = (m_cwp + NW - 1) % NW;
      end else begin
        m_err = 1;
      end
    end else if (rett_req) begin
      nxt = (m_cwp + 1) % NW;
      if (WIM[nxt]) m_unf = 1;
      else begin m_cwp = nxt; m_s = m_ps; m_et = 1; end
    end else if (wrpsr_we) begin
      m_icc = int'(wrpsr_data[11:8]);
      m_s   = int'(wrpsr_data[7]);
      m_ps  = int'(wrpsr_data[6]);
      m_et  = int'(wrpsr_data[5]);
      m_cwp = int'(wrpsr_data[1:0]);
    end else if (save_req && restore_req) begin
      // both ignored
    end else if (save_req) begin
      nxt = (m_cwp + NW - 1) % NW;
      if (WIM[nxt]) m_ovf = 1; else m_cwp = nxt;
    end else if (restore_req) begin
      nxt = (m_cwp + 1) % NW;
      if (WIM[nxt]) m_unf = 1; else m_cwp = nxt;
    end else if (icc_we) begin
      m_icc = int'(icc_in);
    end
  endtask

  task automatic idle_inputs();
    icc_we = 0; icc_in = 0; wrpsr_we = 0; wrpsr_data = 0; save_req = 0;
    restore_req = 0; trap_entry = 0; rett_req = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wrpsr(input logic [11:0] d);
    idle_inputs();
    wrpsr_we = 1; wrpsr_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    WIM = 0;
    reset_n = 1;
    #3 reset_n = 0;
    #1;
    model_reset();
    n_tests++;
    if (PSR !== 12'h080) begin n_fail++; $display("FAIL reset_psr: got %h want 080", PSR); end
    n_tests++;
    if ({win_ovf, win_unf, error_mode} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {win_ovf, win_unf, error_mode});
    end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    do_wrpsr(12'hFA3);
    n_tests++;
    if (PSR !== 12'hFA3) begin n_fail++; $display("FAIL wrpsr_load: got %h want fa3", PSR); end
    // Asynchronous reset away from any clock edge
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    model_reset();
    n_tests++;
    if (PSR !== 12'h080) begin n_fail++; $display("FAIL reset_async: got %h want 080", PSR); end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_window_moves();
    idle_inputs();
    WIM = 4'b0000;
    save_req = 1; tick(); idle_inputs();
    n_tests++;
    if (CWP !== 2'd3 || win_ovf !== 1'b0) begin
      n_fail++; $display("FAIL save_wrap: cwp=%0d ovf=%b want cwp=3 ovf=0", CWP, win_ovf);
    end
    restore_req = 1; tick(); idle_inputs();
    n_tests++;
    if (CWP !== 2'd0 || win_unf !== 1'b0) begin
      n_fail++; $display("FAIL restore_wrap: cwp=%0d unf=%b want cwp=0 unf=0", CWP, win_unf);
    end
    restore_req = 1; tick(); idle_inputs();
    n_tests++;
    if (CWP !== 2'd1 || win_unf !== 1'b0) begin
      n_fail++; $display("FAIL restore_inc: cwp=%0d unf=%b want cwp=1 unf=0", CWP, win_unf);
    end
  endtask

  task automatic test_overflow();
    do_wrpsr(12'h080);
    WIM = 4'b1000;
    save_req = 1; tick(); idle_inputs();
    n_tests++;
    if (CWP !== 2'd0 || win_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pulse: cwp=%0d ovf=%b want cwp=0 ovf=1", CWP, win_ovf);
    end
    tick();
    n_tests++;
    if (win_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", win_ovf); end
    do_wrpsr(12'h083);
    WIM = 4'b0001;
    restore_req = 1; tick(); idle_inputs();
    n_tests++;
    if (CWP !== 2'd3 || win_unf !== 1'b1) begin
      n_fail++; $display("FAIL unf_pulse: cwp=%0d unf=%b want cwp=3 unf=1", CWP, win_unf);
    end
    tick();
    n_tests++;
    if (win_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", win_unf); end
    WIM = 0;
  endtask

  task automatic test_trap_rett();
    do_wrpsr(12'h0A1);
    trap_entry = 1; tick(); idle_inputs();
    n_tests++;
    if (PSR !== 12'h0C0) begin n_fail++; $display("FAIL trap_entry: got %h want 0c0", PSR); end
    WIM = 0;
    rett_req = 1; tick(); idle_inputs();
    n_tests++;
    if (S !== 1'b1 || ET !== 1'b1 || CWP !== 2'd1) begin
      n_fail++; $display("FAIL rett: S=%b ET=%b CWP=%0d want S=1 ET=1 CWP=1", S, ET, CWP);
    end
    n_tests++;
    if (PSR !== exp_psr()) begin n_fail++; $display("FAIL rett_psr: got %h want %h", PSR, exp_psr()); end
    trap_entry = 1; tick(); idle_inputs();
    trap_entry = 1; tick(); idle_inputs();
    n_tests++;
    if (error_mode !== 1'b1 || PSR !== exp_psr()) begin
      n_fail++; $display("FAIL error_mode: err=%b psr=%h want err=1 psr=%h", error_mode, PSR, exp_psr());
    end
    tick();
    n_tests++;
    if (error_mode !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b want 1", error_mode); end
  endtask

  task automatic test_priority();
    do_wrpsr(12'h5A2);
    trap_entry = 1; wrpsr_we = 1; wrpsr_data = 12'hF3F; icc_we = 1; icc_in = 4'hC;
    tick(); idle_inputs();
    // icc=5, PS=S=1, S=1, ET=0, CWP=1
    n_tests++;
    if (PSR !== 12'h5C1) begin n_fail++; $display("FAIL priority: got %h want 5c1", PSR); end
  endtask

  task automatic test_icc();
    logic [3:0] pre;
    do_wrpsr(12'h0A0);
    icc_we = 1; icc_in = 4'b1001;
    #1;
    pre = exp_flags_now();
    n_tests++;
    if ({N, Z, V, C} !== pre) begin
      n_fail++; $display("FAIL icc_same_cycle: got %b want %b", {N, Z, V, C}, pre);
    end
    tick(); idle_inputs();
    n_tests++;
    if (N !== 1'b1 || C !== 1'b1 || PSR[11:8] !== 4'b1001) begin
      n_fail++; $display("FAIL icc_next_cycle: nzvc=%b psr_icc=%b want 1001", {N, Z, V, C}, PSR[11:8]);
    end
  endtask

  task automatic test_random();
    logic [3:0] f;
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      trap_entry  = ($urandom_range(0, 99) < 4);
      rett_req    = ($urandom_range(0, 99) < 8);
      wrpsr_we    = ($urandom_range(0, 99) < 8);
      wrpsr_data  = 12'($urandom);
      save_req    = ($urandom_range(0, 99) < 25);
      restore_req = ($urandom_range(0, 99) < 25);
      icc_we      = ($urandom_range(0, 99) < 50);
      icc_in      = 4'($urandom);
      WIM         = 4'($urandom & $urandom);
      if (save_req && restore_req) icc_we = 0;
      #1;
      f = exp_flags_now();
      n_tests++;
      if ({N, Z, V, C} !== f) begin
        n_fail++; $display("FAIL rnd_flags_pre[%0d]: got %b want %b", i, {N, Z, V, C}, f);
      end
      tick();
      n_tests++;
      if (PSR !== exp_psr() || win_ovf !== 1'(m_ovf) || win_unf !== 1'(m_unf)
          || error_mode !== 1'(m_err)) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: psr=%h ovf=%b unf=%b err=%b want psr=%h ovf=%0d unf=%0d err=%0d",
                 i, PSR, win_ovf, win_unf, error_mode, exp_psr(), m_ovf, m_unf, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_window_moves();
    test_overflow();
    test_trap_rett();
    test_priority();
    test_icc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psr_window_unit.md
Name: psr_window_unit

Overview:
- Holds the 12-bit Processor Status Register: integer condition codes (icc), supervisor bits, trap enable and current window pointer (CWP).
- Sits directly upstream of the branch/trap condition tester and drives its PSR, C, N, V and Z inputs.
- Applies ALU icc updates, WRPSR writes, SAVE/RESTORE window moves, trap entry and RETT.
- Checks every window move against WIM and raises registered window overflow/underflow trap requests.

Parameters:
- NWINDOWS, 4, number of register windows; must be a power of 2; equals WIM width.
- CWPW, 2, CWP width, log2(NWINDOWS).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- icc_we, input, 1, load icc from icc_in.
- icc_in, input, 4, {N,Z,V,C} from ALU.
- wrpsr_we, input, 1, write PSR from wrpsr_data.
- wrpsr_data, input, 12, new PSR value.
- save_req, input, 1, SAVE instruction: CWP decrement.
- restore_req, input, 1, RESTORE instruction: CWP increment.
- trap_entry, input, 1, trap taken.
- rett_req, input, 1, return from trap.
- WIM, input, NWINDOWS, window invalid mask.
- PSR, output, 12, register contents.
- N, Z, V, C, output, 1 each, icc bits to the condition tester.
- CWP, output, CWPW, current window.
- S, output, 1, supervisor bit.
- ET, output, 1, trap enable.
- win_ovf, output, 1, one-cycle window overflow trap request.
- win_unf, output, 1, one-cycle window underflow trap request.
- error_mode, output, 1, sticky; set by a trap while ET=0.

Behaviour:
- PSR layout: [11]=N, [10]=Z, [9]=V, [8]=C, [7]=S, [6]=PS, [5]=ET, [4:2]=reserved, [1:0]=CWP.
  - Reserved bits always read 0 and ignore writes.
- Reset (reset_n=0, async): icc=0000, S=1, PS=0, ET=0, CWP=0, win_ovf=0, win_unf=0, error_mode=0. PSR therefore reads 12'h080.
- Priority each cycle, highest first; exactly one class acts: trap_entry > rett_req > wrpsr_we > save_req/restore_req > icc_we.
  - A lower-priority request in the same cycle is dropped; no queuing.
- trap_entry, ET=1: PS<=S, S<=1, ET<=0, CWP<=CWP-1 mod NWINDOWS. WIM is not checked on trap entry; icc unchanged.
- trap_entry, ET=0: error_mode<=1 (sticky until reset); no other state changes.
- rett_req:
  - nxt=CWP+1 mod NWINDOWS.
  - WIM[nxt]=1: win_unf<=1; CWP, S and ET unchanged.
  - Otherwise: CWP<=nxt, S<=PS, ET<=1.
- wrpsr_we: all non-reserved fields load from wrpsr_data in one cycle. CWP loads wrpsr_data[CWPW-1:0] unchecked.
- save_req:
  - nxt=CWP-1 mod NWINDOWS; wraps 0->NWINDOWS-1.
  - WIM[nxt]=1: win_ovf<=1, CWP held.
  - Otherwise: CWP<=nxt.
- restore_req:
  - nxt=CWP+1 mod NWINDOWS; wraps NWINDOWS-1->0.
  - WIM[nxt]=1: win_unf<=1, CWP held.
  - Otherwise: CWP<=nxt.
- save_req and restore_req together: no-op, both ignored, no trap request.
- icc_we: {N,Z,V,C}<=icc_in. Result is visible on outputs the next cycle (1-cycle latency).
- win_ovf/win_unf are registered pulses, high for exactly one cycle after the offending request, otherwise 0.
- Outputs are driven directly from registers; no combinational input-to-output paths except under the optional feature.

Optional Feature:
- Macro: PSR_ICC_BYPASS_EN.
- Defined: when icc_we=1 and no higher-priority request is active, outputs N, Z, V, C are driven combinationally from icc_in in the same cycle. The condition tester then resolves a branch immediately after a flag-setting op with zero latency.
  - PSR[11:8] stays the registered value.
- Undefined: N, Z, V, C are always the registered bits.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> PSR=12'h080 immediately, no clock needed; win_ovf=win_unf=error_mode=0.
- Window moves, WIM=4'b0000, CWP=0: save_req -> CWP=3. Then restore_req x2 -> CWP=0, then 1. No trap pulses.
- Overflow: CWP=0, WIM=4'b1000, save_req -> CWP stays 0; win_ovf=1 for one cycle then 0.
- Trap/RETT:
  - Setup: wrpsr_data=12'h0A1, i.e. S=1, ET=1, CWP=1.
  - trap_entry -> PSR=12'h0C0 (S=1, PS=1, ET=0, CWP=0).
  - rett_req with WIM=0 -> PSR=12'h0A1.
  - trap_entry with ET=0 -> error_mode=1, PSR unchanged.
- Priority: trap_entry, wrpsr_we and icc_we same cycle -> only trap effects; icc unchanged.
- icc: icc_we=1, icc_in=4'b1001 -> N=1, C=1 next cycle without bypass; same cycle with PSR_ICC_BYPASS_EN defined; PSR[11:8]=4'b1001 next cycle in both builds.
